// File: rtl/jtshouse_scr_mmr.sv
// Scroll-layer memory-mapped register file: 32 CPU-writable bytes decoded into
// scroll offsets, palette banks, priorities and layer-disable flags.
module jtshouse_scr_mmr (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rnw,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [63:0] hscr,
  output logic [63:0] vscr,
  output logic [17:0] pal,
  output logic [17:0] prio,
  output logic [5:0]  enb,
  input  logic [4:0]  ioctl_addr,
  output logic [7:0]  ioctl_din,
  input  logic [7:0]  debug_bus,
  output logic [7:0]  st_dout
);

  logic [7:0] regs_q [0:31];
  logic [7:0] regs_d [0:31];
  logic       unused_dbg;

  always_comb begin
    regs_d = regs_q;
    if (cs && !rnw) regs_d[addr] = din;
  end

  // Reset clears the whole file and wins over a coincident CPU write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) regs_q[k] <= 8'h00;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign dout       = regs_q[addr];
  assign ioctl_din  = regs_q[ioctl_addr];
  assign st_dout    = regs_q[debug_bus[4:0]];
  assign unused_dbg = ^debug_bus[7:5];

  // Scroll words are big-endian byte pairs; layer attribute bytes live at 0x10/0x18.
  always_comb begin
    hscr = '0;
    vscr = '0;
    pal  = '0;
    prio = '0;
    enb  = '0;
    for (int i = 0; i < 4; i++) begin
      hscr[16*i +: 16] = {regs_q[4*i],   regs_q[4*i+1]};
      vscr[16*i +: 16] = {regs_q[4*i+2], regs_q[4*i+3]};
    end
    for (int j = 0; j < 6; j++) begin
      prio[3*j +: 3] = regs_q[16+j][2:0];
      enb[j]         = regs_q[16+j][3];
      pal[3*j +: 3]  = regs_q[24+j][2:0];
    end
  end

endmodule

// File: tb/tb_jtshouse_scr_mmr.sv
// Self-checking bench for jtshouse_scr_mmr: directed scenarios plus a
// randomized run against a byte-array reference model.
module tb_jtshouse_scr_mmr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic [4:0]  addr = '0;
  logic        rnw = 1'b1;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic [63:0] hscr;
  logic [63:0] vscr;
  logic [17:0] pal;
  logic [17:0] prio;
  logic [5:0]  enb;
  logic [4:0]  ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic [7:0]  debug_bus = '0;
  logic [7:0]  st_dout;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [32];

  jtshouse_scr_mmr dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rnw(rnw), .din(din),
    .dout(dout), .hscr(hscr), .vscr(vscr), .pal(pal), .prio(prio), .enb(enb),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .debug_bus(debug_bus), .st_dout(st_dout)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < 32; k++) model[k] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs = 1'b0; rnw = 1'b1;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rnw = 1'b0; addr = a; din = d;
    @(posedge clk);
    model[a] = d;
    #1;
    cs = 1'b0; rnw = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 32; a++) begin
      addr = a[4:0]; ioctl_addr = a[4:0]; debug_bus = {3'b101, a[4:0]};
      #1;
      checks++;
      if (dout !== 8'h00) begin
        failures++; $display("FAIL reset_dout a=%0h got=%h exp=00", a, dout);
      end
      checks++;
      if (ioctl_din !== 8'h00 || st_dout !== 8'h00) begin
        failures++; $display("FAIL reset_dump a=%0h got=%h/%h exp=00/00", a, ioctl_din, st_dout);
      end
    end
    checks++;
    if (hscr !== 64'h0 || vscr !== 64'h0) begin
      failures++; $display("FAIL reset_scroll got=%h/%h exp=0/0", hscr, vscr);
    end
    checks++;
    if (pal !== 18'h0 || prio !== 18'h0 || enb !== 6'h0) begin
      failures++; $display("FAIL reset_attr got=%h/%h/%b exp=0/0/0", pal, prio, enb);
    end
  endtask

  task automatic test_scroll();
    do_reset();
    do_write(5'h04, 8'h12);
    do_write(5'h05, 8'h34);
    do_write(5'h06, 8'hAB);
    do_write(5'h07, 8'hCD);
    #1;
    checks++;
    if (hscr !== 64'h0000_0000_1234_0000) begin
      failures++; $display("FAIL scroll_h got=%h exp=0000000012340000", hscr);
    end
    checks++;
    if (vscr !== 64'h0000_0000_ABCD_0000) begin
      failures++; $display("FAIL scroll_v got=%h exp=00000000abcd0000", vscr);
    end
  endtask

  task automatic test_prio_pal();
    do_reset();
    do_write(5'h12, 8'h0D);
    do_write(5'h1B, 8'hFE);
    #1;
    checks++;
    if (prio !== 18'h00140) begin
      failures++; $display("FAIL prio_map got=%h exp=00140", prio);
    end
    checks++;
    if (enb !== 6'b000100) begin
      failures++; $display("FAIL enb_map got=%b exp=000100", enb);
    end
    checks++;
    if (pal !== 18'h00C00) begin
      failures++; $display("FAIL pal_map got=%h exp=00c00", pal);
    end
    addr = 5'h12; #1;
    checks++;
    if (dout !== 8'h0D) begin
      failures++; $display("FAIL readback_12 got=%h exp=0d", dout);
    end
    addr = 5'h1B; #1;
    checks++;
    if (dout !== 8'hFE) begin
      failures++; $display("FAIL readback_1b got=%h exp=fe", dout);
    end
  endtask

  task automatic test_write_gating();
    do_reset();
    @(negedge clk);
    cs = 1'b0; rnw = 1'b0; addr = 5'h1F; din = 8'h55;
    @(posedge clk); #1;
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL gate_cs0 got=%h exp=00", dout);
    end
    @(negedge clk);
    cs = 1'b1; rnw = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL gate_read got=%h exp=00", dout);
    end
    cs = 1'b0;
    do_write(5'h1F, 8'h55);
    ioctl_addr = 5'h1F; debug_bus = 8'hFF; #1;
    checks++;
    if (ioctl_din !== 8'h55) begin
      failures++; $display("FAIL ioctl_1f got=%h exp=55", ioctl_din);
    end
    checks++;
    if (st_dout !== 8'h55) begin
      failures++; $display("FAIL debug_ff got=%h exp=55", st_dout);
    end
  endtask

  task automatic test_reset_priority();
    do_write(5'h05, 8'h99);
    @(negedge clk);
    rst = 1'b1; cs = 1'b1; rnw = 1'b0; addr = 5'h00; din = 8'h77;
    @(posedge clk);
    model_clear();
    #1;
    rst = 1'b0; cs = 1'b0; rnw = 1'b1;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL rst_vs_write got=%h exp=00", dout);
    end
    addr = 5'h05; #1;
    checks++;
    if (dout !== 8'h00 || hscr !== 64'h0) begin
      failures++; $display("FAIL rst_midseq got=%h/%h exp=00/0", dout, hscr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    cs = 1'b1; rnw = 1'b0; addr = 5'h10; din = 8'h11;
    @(posedge clk);
    #1;
    din = 8'h22;
    #1;
    checks++;
    if (dout !== 8'h11) begin
      failures++; $display("FAIL b2b_old_read got=%h exp=11", dout);
    end
    @(posedge clk);
    model[16] = 8'h22;
    #1;
    cs = 1'b0; rnw = 1'b1;
    checks++;
    if (prio[2:0] !== 3'd2 || enb[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_final got=%0d/%b exp=2/0", prio[2:0], enb[0]);
    end
    checks++;
    if (dout !== 8'h22) begin
      failures++; $display("FAIL b2b_dout got=%h exp=22", dout);
    end
  endtask

  task automatic test_random();
    logic [63:0] eh, ev;
    logic [17:0] ep, epr;
    logic [5:0]  ee;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      cs = $urandom_range(0, 3) != 0;
      rnw = $urandom_range(0, 3) == 0;
      addr = 5'($urandom);
      din = 8'($urandom);
      ioctl_addr = 5'($urandom);
      debug_bus = 8'($urandom);
      #1;
      checks++;
      if (dout !== model[addr]) begin
        failures++; $display("FAIL rand_pre_dout n=%0d got=%h exp=%h", n, dout, model[addr]);
      end
      @(posedge clk);
      if (rst) model_clear();
      else if (cs && !rnw) model[addr] = din;
      #1;
      eh = '0; ev = '0; ep = '0; epr = '0; ee = '0;
      for (int i = 0; i < 4; i++) begin
        eh[16*i +: 16] = 16'(model[4*i] * 256 + model[4*i+1]);
        ev[16*i +: 16] = 16'(model[4*i+2] * 256 + model[4*i+3]);
      end
      for (int j = 0; j < 6; j++) begin
        epr[3*j +: 3] = 3'(model[16+j] % 8);
        ee[j]         = 1'((model[16+j] / 8) % 2);
        ep[3*j +: 3]  = 3'(model[24+j] % 8);
      end
      checks++;
      if (dout !== model[addr]) begin
        failures++; $display("FAIL rand_dout n=%0d got=%h exp=%h", n, dout, model[addr]);
      end
      checks++;
      if (ioctl_din !== model[ioctl_addr] || st_dout !== model[debug_bus % 32]) begin
        failures++; $display("FAIL rand_dump n=%0d got=%h/%h exp=%h/%h", n, ioctl_din, st_dout,
                             model[ioctl_addr], model[debug_bus % 32]);
      end
      checks++;
      if (hscr !== eh || vscr !== ev) begin
        failures++; $display("FAIL rand_scroll n=%0d got=%h/%h exp=%h/%h", n, hscr, vscr, eh, ev);
      end
      checks++;
      if (pal !== ep || prio !== epr || enb !== ee) begin
        failures++; $display("FAIL rand_attr n=%0d got=%h/%h/%b exp=%h/%h/%b", n, pal, prio, enb,
                             ep, epr, ee);
      end
    end
    @(negedge clk);
    rst = 1'b0; cs = 1'b0; rnw = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_prio_pal();
    test_write_gating();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
